// File: rtl/fib_bcd_converter.sv
// rtl/fib_bcd_converter.sv - sequential shift-and-add-3 binary-to-BCD converter
// Converts one input bit per clock; result held in bcd between conversions.
module fib_bcd_converter #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [W-1:0]        shift_reg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adjusted;
  logic [4*DIGITS-1:0] scratch_next;
  logic [CW-1:0]       count;
  logic                last_iter;

  // Digits are corrected independently before the shift; no carry crosses digits.
  always_comb begin
    adjusted = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    scratch_next = {adjusted[4*DIGITS-2:0], shift_reg[W-1]};
    last_iter    = (count == CW'(W - 1));
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      bcd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            count     <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[W-2:0], 1'b0};
          scratch   <= scratch_next;
          if (last_iter) begin
            bcd <= scratch_next;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_bcd_converter.sv
// tb/tb_fib_bcd_converter.sv - self-checking bench for fib_bcd_converter
// Directed vector table, handshake corner sequences and an exhaustive sweep.
module tb_fib_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] bin;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[12];

  fib_bcd_converter #(.W(12), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // lat = negedges after the accept edge until done is seen (13 means done after edge k+12).
  task automatic do_conv(input logic [11:0] b, output logic [15:0] res,
                         output int lat, output int busy_cycles);
    @(posedge clk); #1;
    bin   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 12'($urandom);
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
    res = bcd;
  endtask

  initial begin
    logic [15:0] res;
    int lat, bc, ndone, first, last, gap_err;

    vecs[0]  = '{12'd0,    16'h0000};
    vecs[1]  = '{12'd1,    16'h0001};
    vecs[2]  = '{12'd55,   16'h0055};
    vecs[3]  = '{12'd610,  16'h0610};
    vecs[4]  = '{12'd4095, 16'h4095};
    vecs[5]  = '{12'd9,    16'h0009};
    vecs[6]  = '{12'd100,  16'h0100};
    vecs[7]  = '{12'd999,  16'h0999};
    vecs[8]  = '{12'd1000, 16'h1000};
    vecs[9]  = '{12'd2048, 16'h2048};
    vecs[10] = '{12'd987,  16'h0987};
    vecs[11] = '{12'd2584, 16'h2584};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd), 32'h0000);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_conv(vecs[i].bin, res, lat, bc);
      check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd13);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd12);
    end

    do_conv(12'd55, res, lat, bc);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("bcd_hold", 32'(bcd), 32'h0055);

    // start raised mid-SHIFT must be ignored
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 12'd89;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 12'd0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 12'd144;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_busy_dones", 32'(ndone), 32'd1);
    check("ignore_busy_bcd", 32'(bcd), 32'h0089);

    // reset in the middle of a conversion
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 12'd377;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_dones", 32'(ndone), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0000);
    check("abort_busy", 32'(busy), 32'd0);
    do_conv(12'd233, res, lat, bc);
    check("after_abort_bcd", 32'(res), 32'h0233);
    check("after_abort_latency", 32'(lat), 32'd13);

    // start held high: one conversion every 14 cycles
    @(posedge clk); #1;
    start = 1'b1;
    bin   = 12'd987;
    ndone = 0;
    first = -1;
    last  = -1;
    gap_err = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = n;
        else if (n - last != 14) gap_err++;
        last = n;
      end
    end
    check("b2b_first_done", 32'(first), 32'd14);
    check("b2b_done_count", 32'(ndone), 32'd4);
    check("b2b_gap_errors", 32'(gap_err), 32'd0);
    check("b2b_bcd", 32'(bcd), 32'h0987);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 4096; i++) begin
      do_conv(12'(i), res, lat, bc);
      check($sformatf("sweep%0d_bcd", i), 32'(res), 32'(model(i)));
      check($sformatf("sweep%0d_latency", i), 32'(lat), 32'd13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
